// File: rtl/rob_pkg.sv
// Shared ROB-side definitions: widths, commit bundle and the regfile controller state type.
package rob_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_IDX_W = 3;
  localparam int unsigned ROB_DEPTH = 1 << ROB_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0]    data;
  } commit_t;

  typedef enum logic [0:0] {StIdle, StFlush} rf_state_e;

endpackage

// File: rtl/commit_regfile_if.sv
// ROB-to-regfile commit handshake: the ROB head drives a valid commit bundle, the regfile accepts it.
interface commit_regfile_if;
  import rob_pkg::*;

  logic    commit_valid;
  logic    commit_ready;
  commit_t commit;

  modport master (output commit_valid, output commit, input commit_ready);
  modport slave  (input commit_valid, input commit, output commit_ready);

endinterface

// File: rtl/regfile_status_entry.sv
// Register-status entry for one architectural register: busy bit plus the producing ROB tag.
module regfile_status_entry import rob_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_en_i,
  input  logic [ROB_IDX_W-1:0] alloc_rob_i,
  input  logic                 commit_en_i,
  input  logic [ROB_IDX_W-1:0] commit_rob_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic [ROB_IDX_W-1:0] tag_o
);

  logic                 busy_q, busy_d;
  logic [ROB_IDX_W-1:0] tag_q, tag_d;

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    // Only the commit of the latest rename may release the register.
    if (commit_en_i && (tag_q == commit_rob_i)) busy_d = 1'b0;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (alloc_en_i) begin
      busy_d = 1'b1;
      tag_d  = alloc_rob_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy_o = busy_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/commit_regfile.sv
// Architectural register file fed by in-order ROB commits, with register-status table and
// two combinational operand read ports that bypass a same-cycle commit.
module commit_regfile import rob_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  commit_regfile_if.slave      cmt_if,
  input  logic                 alloc_valid_i,
  input  logic [REG_IDX_W-1:0] alloc_reg_i,
  input  logic [ROB_IDX_W-1:0] alloc_rob_i,
  input  logic                 flush_i,
  input  logic [REG_IDX_W-1:0] rd_addr_a_i,
  input  logic [REG_IDX_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0]    rd_data_a_o,
  output logic [DATA_W-1:0]    rd_data_b_o,
  output logic                 rd_busy_a_o,
  output logic                 rd_busy_b_o,
  output logic [ROB_IDX_W-1:0] rd_tag_a_o,
  output logic [ROB_IDX_W-1:0] rd_tag_b_o,
  output logic [31:0]          retire_cnt_o
);

  rf_state_e state_q, state_d;
  logic      idle, fire, flush_clr, alloc_en;

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [31:0]          retire_cnt_q;
  logic [NUM_REGS-1:0]  busy;
  logic [ROB_IDX_W-1:0] tag [NUM_REGS];

  assign idle      = (state_q == StIdle);
  assign cmt_if.commit_ready = rst_n & idle;
  assign fire      = cmt_if.commit_valid & cmt_if.commit_ready;
  assign flush_clr = idle & flush_i;
  assign alloc_en  = idle & ~flush_i & alloc_valid_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush_i) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      retire_cnt_q <= '0;
    end else if (fire) begin
      if (cmt_if.commit.idx != '0) regs_q[cmt_if.commit.idx] <= cmt_if.commit.data;
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign busy[0] = 1'b0;
  assign tag[0]  = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_status
    regfile_status_entry u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_en_i   (alloc_en && (alloc_reg_i == REG_IDX_W'(i))),
      .alloc_rob_i  (alloc_rob_i),
      .commit_en_i  (fire && (cmt_if.commit.idx == REG_IDX_W'(i))),
      .commit_rob_i (cmt_if.commit.rob),
      .flush_i      (flush_clr),
      .busy_o       (busy[i]),
      .tag_o        (tag[i])
    );
  end

  logic [REG_IDX_W-1:0] rd_addr [2];
  logic [DATA_W-1:0]    rd_data [2];
  logic                 rd_busy [2];
  logic [ROB_IDX_W-1:0] rd_tag  [2];

  assign rd_addr[0] = rd_addr_a_i;
  assign rd_addr[1] = rd_addr_b_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      rd_tag[p]  = tag[rd_addr[p]];
      if (rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
        rd_tag[p]  = '0;
      end else if (fire && (cmt_if.commit.idx == rd_addr[p]) &&
                   (tag[rd_addr[p]] == cmt_if.commit.rob)) begin
        rd_data[p] = cmt_if.commit.data;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a_o  = rd_data[0];
  assign rd_data_b_o  = rd_data[1];
  assign rd_busy_a_o  = rd_busy[0];
  assign rd_busy_b_o  = rd_busy[1];
  assign rd_tag_a_o   = rd_tag[0];
  assign rd_tag_b_o   = rd_tag[1];
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_commit_regfile.sv
// Directed and randomized checks of commit_regfile against an array-based architectural model.
module tb_commit_regfile;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_regfile_if cif ();

  logic                 alloc_valid, flush;
  logic [REG_IDX_W-1:0] alloc_reg, ra, rb;
  logic [ROB_IDX_W-1:0] alloc_rob;
  logic [DATA_W-1:0]    rd_data_a, rd_data_b;
  logic                 rd_busy_a, rd_busy_b;
  logic [ROB_IDX_W-1:0] rd_tag_a, rd_tag_b;
  logic [31:0]          retire_cnt;

  commit_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmt_if       (cif.slave),
    .alloc_valid_i(alloc_valid),
    .alloc_reg_i  (alloc_reg),
    .alloc_rob_i  (alloc_rob),
    .flush_i      (flush),
    .rd_addr_a_i  (ra),
    .rd_addr_b_i  (rb),
    .rd_data_a_o  (rd_data_a),
    .rd_data_b_o  (rd_data_b),
    .rd_busy_a_o  (rd_busy_a),
    .rd_busy_b_o  (rd_busy_b),
    .rd_tag_a_o   (rd_tag_a),
    .rd_tag_b_o   (rd_tag_b),
    .retire_cnt_o (retire_cnt)
  );

  // Architectural model
  logic [DATA_W-1:0]    m_reg  [NUM_REGS];
  bit                   m_busy [NUM_REGS];
  logic [ROB_IDX_W-1:0] m_tag  [NUM_REGS];
  logic [31:0]          m_cnt;
  bit                   m_flushing;
  bit                   last_fire;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_reg[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
    end
    m_cnt = '0;
    m_flushing = 0;
  endtask

  task automatic idle_in();
    cif.commit_valid = 1'b0;
    cif.commit       = '0;
    alloc_valid = 1'b0; alloc_reg = '0; alloc_rob = '0;
    flush = 1'b0; ra = '0; rb = '0;
  endtask

  task automatic expect_rd(input logic [REG_IDX_W-1:0] a, output logic [DATA_W-1:0] d,
                           output logic b, output logic [ROB_IDX_W-1:0] t);
    bit fires;
    fires = cif.commit_valid && !m_flushing;
    if (a == 0) begin
      d = '0; b = 1'b0; t = '0;
    end else if (fires && cif.commit.idx == a && cif.commit.rob == m_tag[a]) begin
      d = cif.commit.data; b = 1'b0; t = m_tag[a];
    end else begin
      d = m_reg[a]; b = m_busy[a]; t = m_tag[a];
    end
  endtask

  task automatic sample();
    logic [DATA_W-1:0] d; logic b; logic [ROB_IDX_W-1:0] t;
    #1;
    chk("commit_ready", 32'(cif.commit_ready), 32'(!m_flushing));
    chk("retire_cnt", retire_cnt, m_cnt);
    expect_rd(ra, d, b, t);
    chk("rd_data_a", rd_data_a, d);
    chk("rd_busy_a", 32'(rd_busy_a), 32'(b));
    chk("rd_tag_a", 32'(rd_tag_a), 32'(t));
    expect_rd(rb, d, b, t);
    chk("rd_data_b", rd_data_b, d);
    chk("rd_busy_b", 32'(rd_busy_b), 32'(b));
    chk("rd_tag_b", 32'(rd_tag_b), 32'(t));
  endtask

  task automatic tick();
    bit fires;
    @(posedge clk);
    fires = cif.commit_valid && !m_flushing;
    last_fire = fires;
    if (fires) begin
      if (cif.commit.idx != 0) m_reg[cif.commit.idx] = cif.commit.data;
      m_cnt = m_cnt + 1;
      if (cif.commit.idx != 0 && m_tag[cif.commit.idx] == cif.commit.rob)
        m_busy[cif.commit.idx] = 0;
    end
    if (m_flushing) begin
      m_flushing = 0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
      m_flushing = 1;
    end else if (alloc_valid && alloc_reg != 0) begin
      m_busy[alloc_reg] = 1;
      m_tag[alloc_reg]  = alloc_rob;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic do_alloc(input int r, input int t);
    idle_in();
    alloc_valid = 1'b1; alloc_reg = REG_IDX_W'(r); alloc_rob = ROB_IDX_W'(t);
  endtask

  task automatic do_commit(input int r, input int t, input logic [31:0] d);
    cif.commit_valid = 1'b1;
    cif.commit.idx = REG_IDX_W'(r); cif.commit.rob = ROB_IDX_W'(t); cif.commit.data = d;
  endtask

  initial begin
    bit hold;
    idle_in();
    m_reset();
    // 1: reset
    #12;
    chk("ready_in_reset", 32'(cif.commit_ready), 32'd0);
    chk("cnt_in_reset", retire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ra = 5'd5;
    sample();
    chk("r5_data", rd_data_a, 32'd0);
    chk("ready_after_rst", 32'(cif.commit_ready), 32'd1);
    tick();

    // 2: alloc then tag-matching commit with bypass
    do_alloc(3, 2); ra = 5'd3; cyc();
    idle_in(); ra = 5'd3; sample();
    chk("r3_busy", 32'(rd_busy_a), 32'd1);
    chk("r3_tag", 32'(rd_tag_a), 32'd2);
    tick();
    do_commit(3, 2, 32'hDEAD_BEEF); ra = 5'd3; sample();
    chk("r3_bypass_data", rd_data_a, 32'hDEAD_BEEF);
    chk("r3_bypass_busy", 32'(rd_busy_a), 32'd0);
    tick();
    idle_in(); ra = 5'd3; sample();
    chk("r3_busy_after", 32'(rd_busy_a), 32'd0);
    chk("cnt_one", retire_cnt, 32'd1);
    tick();

    // 3: stale commit must not clear a newer rename
    do_alloc(4, 1); cyc();
    do_alloc(4, 5); cyc();
    idle_in(); do_commit(4, 1, 32'h11); ra = 5'd4; cyc();
    idle_in(); ra = 5'd4; sample();
    chk("r4_data", rd_data_a, 32'h11);
    chk("r4_busy", 32'(rd_busy_a), 32'd1);
    chk("r4_tag", 32'(rd_tag_a), 32'd5);
    tick();

    // 4: same-cycle alloc and commit on one register
    do_alloc(7, 6); do_commit(7, 6, 32'h77); ra = 5'd7; cyc();
    idle_in(); rb = 5'd7; sample();
    chk("r7_data", rd_data_b, 32'h77);
    chk("r7_busy", 32'(rd_busy_b), 32'd1);
    chk("r7_tag", 32'(rd_tag_b), 32'd6);
    tick();

    // 5: flush with a concurrent commit and a dropped alloc
    do_alloc(1, 1); cyc();
    do_alloc(2, 2); cyc();
    do_alloc(9, 3); cyc();
    do_alloc(10, 4); flush = 1'b1; do_commit(1, 1, 32'h5); ra = 5'd1; rb = 5'd9; cyc();
    do_alloc(11, 2); ra = 5'd1; rb = 5'd9; sample();
    chk("flush_ready", 32'(cif.commit_ready), 32'd0);
    chk("r1_data", rd_data_a, 32'h5);
    chk("r1_busy", 32'(rd_busy_a), 32'd0);
    chk("r9_busy", 32'(rd_busy_b), 32'd0);
    tick();
    idle_in(); ra = 5'd10; rb = 5'd11; sample();
    chk("ready_post_flush", 32'(cif.commit_ready), 32'd1);
    chk("r10_busy", 32'(rd_busy_a), 32'd0);
    chk("r11_busy", 32'(rd_busy_b), 32'd0);
    tick();

    // 6: commit to r0, then reset mid-commit
    do_commit(0, 0, 32'h1234); ra = 5'd0; cyc();
    idle_in(); sample();
    chk("r0_data", rd_data_a, 32'd0);
    chk("cnt_five", retire_cnt, 32'd5);
    tick();
    do_commit(6, 0, 32'h66); ra = 5'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_ready", 32'(cif.commit_ready), 32'd0);
    chk("rst_r3", rd_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    idle_in(); ra = 5'd6; rb = 5'd3; cyc();

    // Randomized traffic
    hold = 0;
    for (int it = 0; it < 600; it++) begin
      if (!hold) begin
        cif.commit_valid = ($urandom_range(0, 1) == 1);
        cif.commit.idx   = REG_IDX_W'($urandom_range(0, NUM_REGS - 1));
        cif.commit.rob   = ($urandom_range(0, 2) != 0) ? m_tag[cif.commit.idx]
                                                         : ROB_IDX_W'($urandom);
        cif.commit.data  = $urandom;
      end
      alloc_valid = ($urandom_range(0, 9) < 4);
      alloc_reg   = REG_IDX_W'($urandom_range(0, NUM_REGS - 1));
      alloc_rob   = ROB_IDX_W'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      ra = ($urandom_range(0, 1) == 1) ? cif.commit.idx : REG_IDX_W'($urandom);
      rb = REG_IDX_W'($urandom);
      cyc();
      hold = cif.commit_valid && !last_fire;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
